// File: rtl/nibble_sort_ctrl_if.sv
// Handshake and data bundle between a nibble loader/consumer and nibble_sort_ctrl.
// master = loader/consumer side, slave = sorter side.
interface nibble_sort_ctrl_if #(
   parameter int N  = 4,
   parameter int CW = 8
);
   logic             start;
   logic [4*N-1:0]   data_in;
   logic [4*N-1:0]   data_out;
   logic             busy;
   logic             done;
   logic [CW-1:0]    swap_count;

   modport master (
      output start, data_in,
      input  data_out, busy, done, swap_count
   );

   modport slave (
      input  start, data_in,
      output data_out, busy, done, swap_count
   );
endinterface

// File: rtl/nibble_sort_ctrl.sv
// Sequential bubble sorter for N nibbles sharing one 4-bit comparator, one compare per cycle.
// Define SORT_DESCEND_EN to sort largest-first; default build sorts ascending.
module fourBitComparator (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       eq,
   output logic       gt,
   output logic       lt
);
   assign eq = (a == b);
   assign gt = (a > b);
   assign lt = (a < b);
endmodule

module nibble_sort_ctrl #(
   parameter int N  = 4,
   parameter int CW = 8
) (
   input  logic             clk,
   input  logic             rst,
   nibble_sort_ctrl_if.slave bus
);
   localparam int IW = $clog2(N);

   typedef enum logic [1:0] {IDLE, COMPARE, SWAP, DONE} state_t;

   state_t          state_q, state_d;
   logic [3:0]      elem_q [N];
   logic [3:0]      elem_d [N];
   logic [IW-1:0]   i_q, i_d, p_q, p_d, i_nxt;
   logic            swapped_q, swapped_d;
   logic [CW-1:0]   swap_count_q, swap_count_d;
   logic [3:0]      cmp_a, cmp_b;
   logic            cmp_eq, cmp_gt, cmp_lt;
   logic            need_swap, advance, pass_end, last_pass;

   assign i_nxt = i_q + IW'(1);
   assign cmp_a = elem_q[i_q];
   assign cmp_b = elem_q[i_nxt];

   fourBitComparator u_cmp (
      .a  (cmp_a),
      .b  (cmp_b),
      .eq (cmp_eq),
      .gt (cmp_gt),
      .lt (cmp_lt)
   );

   // Equal elements must never swap so the sort stays stable.
`ifdef SORT_DESCEND_EN
   assign need_swap = cmp_lt & ~cmp_gt & ~cmp_eq;
`else
   assign need_swap = cmp_gt & ~cmp_lt & ~cmp_eq;
`endif

   assign pass_end  = (32'(i_q) + 32'(p_q)) >= 32'(N - 2);
   assign last_pass = (p_q == IW'(N - 2));

   always_comb begin
      state_d      = state_q;
      i_d          = i_q;
      p_d          = p_q;
      swapped_d    = swapped_q;
      swap_count_d = swap_count_q;
      advance      = 1'b0;
      for (int k = 0; k < N; k++) begin
         elem_d[k] = elem_q[k];
      end

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               for (int k = 0; k < N; k++) begin
                  elem_d[k] = bus.data_in[4*k +: 4];
               end
               swap_count_d = '0;
               swapped_d    = 1'b0;
               p_d          = '0;
               i_d          = '0;
               state_d      = COMPARE;
            end
         end
         COMPARE: begin
            if (need_swap) begin
               state_d = SWAP;
            end else begin
               advance = 1'b1;
            end
         end
         SWAP: begin
            elem_d[i_q]   = cmp_b;
            elem_d[i_nxt] = cmp_a;
            if (swap_count_q != '1) begin
               swap_count_d = swap_count_q + CW'(1);
            end
            swapped_d = 1'b1;
            advance   = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A pass with no swaps proves the vector is sorted, so stop early.
      if (advance) begin
         if (!pass_end) begin
            i_d     = i_nxt;
            state_d = COMPARE;
         end else if (!swapped_d || last_pass) begin
            state_d = DONE;
         end else begin
            p_d       = p_q + IW'(1);
            i_d       = '0;
            swapped_d = 1'b0;
            state_d   = COMPARE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         i_q          <= '0;
         p_q          <= '0;
         swapped_q    <= 1'b0;
         swap_count_q <= '0;
         for (int k = 0; k < N; k++) begin
            elem_q[k] <= '0;
         end
      end else begin
         state_q      <= state_d;
         i_q          <= i_d;
         p_q          <= p_d;
         swapped_q    <= swapped_d;
         swap_count_q <= swap_count_d;
         for (int k = 0; k < N; k++) begin
            elem_q[k] <= elem_d[k];
         end
      end
   end

   always_comb begin
      bus.data_out = '0;
      for (int k = 0; k < N; k++) begin
         bus.data_out[4*k +: 4] = elem_q[k];
      end
   end

   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = (state_q == DONE);
   assign bus.swap_count = swap_count_q;
endmodule
